// File: rtl/mem_arbiter_if.sv
// Memory-side channel of the cache arbiter: one request/completion handshake
// carrying a line index, a write flag and a full line in each direction.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128
);
    logic                 Arb_mem_req;
    logic                 Arb_mem_we;
    logic [ADDR_BITS-1:0] Arb_mem_addr;
    logic [LINE_BITS-1:0] Arb_mem_wline;
    logic [LINE_BITS-1:0] Arb_mem_rline;
    logic                 Arb_mem_valid;

    modport master (
        output Arb_mem_req,
        output Arb_mem_we,
        output Arb_mem_addr,
        output Arb_mem_wline,
        input  Arb_mem_rline,
        input  Arb_mem_valid
    );

    modport slave (
        input  Arb_mem_req,
        input  Arb_mem_we,
        input  Arb_mem_addr,
        input  Arb_mem_wline,
        output Arb_mem_rline,
        output Arb_mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes I-line reads, D-line reads and buffered D write-backs onto one
// single-port memory channel, with a sticky watchdog for a hung memory.
module mem_arbiter #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 10,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [ADDR_BITS-1:0] Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic [ADDR_BITS-1:0] Dc_mem_addr,
    output logic [LINE_BITS-1:0] MEM_data_line,
    output logic                 MEM_mem_valid,
    input  logic                 Dc_wb_we,
    input  logic [ADDR_BITS-1:0] Dc_wb_addr,
    input  logic [LINE_BITS-1:0] Dc_wb_wline,
    output logic                 Dc_wb_busy,
    mem_arbiter_if.master        mem,
    output logic                 Arb_err
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {SRC_I, SRC_D, SRC_W} src_t;

    state_t               state;
    src_t                 src;
    logic                 rr_last_d;
    logic [WD_W-1:0]      wd;
    logic                 wb_valid;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [LINE_BITS-1:0] wb_line;

    logic                 grant;
    src_t                 grant_src;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [LINE_BITS-1:0] grant_line;
    logic                 wd_expired;

    // A write-back pulse arriving in IDLE is granted straight from the inputs,
    // so a D read of the same line raised in that cycle still goes after it.
    always_comb begin
        grant      = 1'b0;
        grant_src  = SRC_I;
        grant_addr = '0;
        grant_line = '0;
        if (wb_valid) begin
            grant      = 1'b1;
            grant_src  = SRC_W;
            grant_addr = wb_addr;
            grant_line = wb_line;
        end else if (Dc_wb_we) begin
            grant      = 1'b1;
            grant_src  = SRC_W;
            grant_addr = Dc_wb_addr;
            grant_line = Dc_wb_wline;
        end else if (Ic_mem_req && (!Dc_mem_req || rr_last_d)) begin
            grant      = 1'b1;
            grant_src  = SRC_I;
            grant_addr = Ic_mem_addr;
        end else if (Dc_mem_req) begin
            grant      = 1'b1;
            grant_src  = SRC_D;
            grant_addr = Dc_mem_addr;
        end
    end

    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
    assign Dc_wb_busy = wb_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            src               <= SRC_I;
            rr_last_d         <= 1'b0;
            wd                <= '0;
            wb_valid          <= 1'b0;
            wb_addr           <= '0;
            wb_line           <= '0;
            F_mem_inst        <= '0;
            F_mem_valid       <= 1'b0;
            MEM_data_line     <= '0;
            MEM_mem_valid     <= 1'b0;
            Arb_err           <= 1'b0;
            mem.Arb_mem_req   <= 1'b0;
            mem.Arb_mem_we    <= 1'b0;
            mem.Arb_mem_addr  <= '0;
            mem.Arb_mem_wline <= '0;
        end else begin
            F_mem_valid   <= 1'b0;
            MEM_mem_valid <= 1'b0;

            if (Dc_wb_we && !wb_valid) begin
                wb_valid <= 1'b1;
                wb_addr  <= Dc_wb_addr;
                wb_line  <= Dc_wb_wline;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        src               <= grant_src;
                        mem.Arb_mem_req   <= 1'b1;
                        mem.Arb_mem_we    <= (grant_src == SRC_W);
                        mem.Arb_mem_addr  <= grant_addr;
                        mem.Arb_mem_wline <= grant_line;
                        wd                <= '0;
                        state             <= BUSY;
                        if (grant_src != SRC_W)
                            rr_last_d <= (grant_src == SRC_D);
                    end
                end
                BUSY: begin
                    if (mem.Arb_mem_valid || wd_expired) begin
                        mem.Arb_mem_req <= 1'b0;
                        state           <= RESP;
                        if (!mem.Arb_mem_valid)
                            Arb_err <= 1'b1;
                        case (src)
                            SRC_I: begin
                                F_mem_inst  <= mem.Arb_mem_valid ? mem.Arb_mem_rline : '0;
                                F_mem_valid <= 1'b1;
                            end
                            SRC_D: begin
                                MEM_data_line <= mem.Arb_mem_valid ? mem.Arb_mem_rline : '0;
                                MEM_mem_valid <= 1'b1;
                            end
                            default: wb_valid <= 1'b0;
                        endcase
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory, checking each
// request and answering with hand-picked lines and latencies.
module tb_mem_arbiter;
    localparam int AB = 10;
    localparam int LB = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          Ic_mem_req;
    logic [AB-1:0] Ic_mem_addr;
    logic [LB-1:0] F_mem_inst;
    logic          F_mem_valid;
    logic          Dc_mem_req;
    logic [AB-1:0] Dc_mem_addr;
    logic [LB-1:0] MEM_data_line;
    logic          MEM_mem_valid;
    logic          Dc_wb_we;
    logic [AB-1:0] Dc_wb_addr;
    logic [LB-1:0] Dc_wb_wline;
    logic          Dc_wb_busy;
    logic          Arb_err;

    int checks = 0;
    int errors = 0;
    int f_cnt  = 0;
    int m_cnt  = 0;
    int f0, m0;

    mem_arbiter_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) mem_bus ();

    mem_arbiter #(.LINE_BITS(LB), .ADDR_BITS(AB), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .Ic_mem_req    (Ic_mem_req),
        .Ic_mem_addr   (Ic_mem_addr),
        .F_mem_inst    (F_mem_inst),
        .F_mem_valid   (F_mem_valid),
        .Dc_mem_req    (Dc_mem_req),
        .Dc_mem_addr   (Dc_mem_addr),
        .MEM_data_line (MEM_data_line),
        .MEM_mem_valid (MEM_mem_valid),
        .Dc_wb_we      (Dc_wb_we),
        .Dc_wb_addr    (Dc_wb_addr),
        .Dc_wb_wline   (Dc_wb_wline),
        .Dc_wb_busy    (Dc_wb_busy),
        .mem           (mem_bus),
        .Arb_err       (Arb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (F_mem_valid)   f_cnt <= f_cnt + 1;
        if (MEM_mem_valid) m_cnt <= m_cnt + 1;
    end

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a memory request, checks it, then completes it in
    // the lat-th cycle of req. Returns in the cycle after completion.
    task automatic serve(input string tag, input logic exp_we, input logic [AB-1:0] exp_addr,
                         input logic [LB-1:0] exp_wline, input int lat, input logic [LB-1:0] rdata);
        int waited = 0;
        while (mem_bus.Arb_mem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_req"}, LB'(mem_bus.Arb_mem_req), LB'(1));
        if (mem_bus.Arb_mem_req !== 1'b1) return;
        check({tag, "_addr"}, LB'(mem_bus.Arb_mem_addr), LB'(exp_addr));
        check({tag, "_we"}, LB'(mem_bus.Arb_mem_we), LB'(exp_we));
        if (exp_we) check({tag, "_wline"}, mem_bus.Arb_mem_wline, exp_wline);
        for (int i = 1; i < lat; i++) begin
            tick();
            check({tag, "_hold"}, LB'(mem_bus.Arb_mem_req), LB'(1));
        end
        mem_bus.Arb_mem_valid = 1'b1;
        mem_bus.Arb_mem_rline = rdata;
        tick();
        mem_bus.Arb_mem_valid = 1'b0;
        mem_bus.Arb_mem_rline = '0;
        check({tag, "_drop"}, LB'(mem_bus.Arb_mem_req), LB'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [LB-1:0] la5, li1, ld1, li2, ld2, w1, w2, r1, r2, w3;
        la5 = {16{8'hA5}};
        li1 = {4{32'h1111_0001}};
        ld1 = {4{32'hDDDD_0001}};
        li2 = {4{32'h1111_0002}};
        ld2 = {4{32'hDDDD_0002}};
        w1  = {4{32'hC0FF_EE01}};
        w2  = {4{32'hBAD0_0002}};
        r1  = {4{32'h5EAD_0001}};
        r2  = {4{32'h5EAD_0002}};
        w3  = {4{32'h7777_0003}};

        Ic_mem_req = 1'b0; Ic_mem_addr = '0;
        Dc_mem_req = 1'b0; Dc_mem_addr = '0;
        Dc_wb_we = 1'b0; Dc_wb_addr = '0; Dc_wb_wline = '0;
        mem_bus.Arb_mem_valid = 1'b0; mem_bus.Arb_mem_rline = '0;
        tick();
        do_reset();

        check("rst_req", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("rst_busy", LB'(Dc_wb_busy), LB'(0));
        check("rst_err", LB'(Arb_err), LB'(0));
        check("rst_fvalid", LB'(F_mem_valid), LB'(0));
        check("rst_finst", F_mem_inst, '0);

        // I-only read, memory answers in the 3rd req cycle.
        f0 = f_cnt; m0 = m_cnt;
        Ic_mem_req = 1'b1; Ic_mem_addr = 10'h005;
        tick();
        check("i_lat1", LB'(mem_bus.Arb_mem_req), LB'(1));
        serve("i_only", 1'b0, 10'h005, '0, 3, la5);
        check("i_fvalid", LB'(F_mem_valid), LB'(1));
        check("i_finst", F_mem_inst, la5);
        check("i_mvalid", LB'(MEM_mem_valid), LB'(0));
        Ic_mem_req = 1'b0;
        tick();
        check("i_fpulse1", LB'(F_mem_valid), LB'(0));
        tick();
        check("i_no_rereq", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("i_fcnt", LB'(f_cnt - f0), LB'(1));
        check("i_mcnt", LB'(m_cnt - m0), LB'(0));

        // I and D together from reset: D wins first, then I, twice.
        do_reset();
        f0 = f_cnt; m0 = m_cnt;
        Ic_mem_req = 1'b1; Ic_mem_addr = 10'h0A1;
        Dc_mem_req = 1'b1; Dc_mem_addr = 10'h0B2;
        serve("rr_d1", 1'b0, 10'h0B2, '0, 1, ld1);
        check("rr_d1_mvalid", LB'(MEM_mem_valid), LB'(1));
        check("rr_d1_line", MEM_data_line, ld1);
        Dc_mem_req = 1'b0;
        serve("rr_i1", 1'b0, 10'h0A1, '0, 2, li1);
        check("rr_i1_fvalid", LB'(F_mem_valid), LB'(1));
        check("rr_i1_line", F_mem_inst, li1);
        Ic_mem_req = 1'b0;
        tick();
        Ic_mem_req = 1'b1; Ic_mem_addr = 10'h0A3;
        Dc_mem_req = 1'b1; Dc_mem_addr = 10'h0B4;
        serve("rr_d2", 1'b0, 10'h0B4, '0, 1, ld2);
        check("rr_d2_line", MEM_data_line, ld2);
        check("rr_i_hold", F_mem_inst, li1);
        Dc_mem_req = 1'b0;
        serve("rr_i2", 1'b0, 10'h0A3, '0, 1, li2);
        check("rr_i2_line", F_mem_inst, li2);
        Ic_mem_req = 1'b0;
        repeat (2) tick();
        check("rr_fcnt", LB'(f_cnt - f0), LB'(2));
        check("rr_mcnt", LB'(m_cnt - m0), LB'(2));

        // Write-back and D read of the same line in one cycle; second write-back dropped.
        Dc_wb_we = 1'b1; Dc_wb_addr = 10'h010; Dc_wb_wline = w1;
        Dc_mem_req = 1'b1; Dc_mem_addr = 10'h010;
        tick();
        Dc_wb_we = 1'b0;
        check("wb_busy_set", LB'(Dc_wb_busy), LB'(1));
        Dc_wb_we = 1'b1; Dc_wb_addr = 10'h020; Dc_wb_wline = w2;
        tick();
        Dc_wb_we = 1'b0;
        check("wb_busy_hold", LB'(Dc_wb_busy), LB'(1));
        serve("wb_write", 1'b1, 10'h010, w1, 2, '0);
        check("wb_busy_clr", LB'(Dc_wb_busy), LB'(0));
        check("wb_no_dpulse", LB'(MEM_mem_valid), LB'(0));
        serve("wb_read", 1'b0, 10'h010, '0, 1, r1);
        check("wb_rd_mvalid", LB'(MEM_mem_valid), LB'(1));
        check("wb_rd_line", MEM_data_line, r1);
        Dc_mem_req = 1'b0;
        repeat (3) tick();
        check("wb_dropped_req", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("wb_dropped_busy", LB'(Dc_wb_busy), LB'(0));

        // Hung memory: req high 8 cycles, then zero line with a valid pulse.
        Ic_mem_req = 1'b1; Ic_mem_addr = 10'h033;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("wd_req_high", LB'(mem_bus.Arb_mem_req), LB'(1));
            tick();
        end
        check("wd_req_drop", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("wd_err", LB'(Arb_err), LB'(1));
        check("wd_fvalid", LB'(F_mem_valid), LB'(1));
        check("wd_zero_line", F_mem_inst, '0);
        Ic_mem_req = 1'b0;
        tick();
        Dc_mem_req = 1'b1; Dc_mem_addr = 10'h044;
        serve("wd_after", 1'b0, 10'h044, '0, 2, r2);
        check("wd_after_line", MEM_data_line, r2);
        check("wd_err_sticky", LB'(Arb_err), LB'(1));
        Dc_mem_req = 1'b0;
        tick();

        // Reset while a buffered write is in flight.
        Dc_wb_we = 1'b1; Dc_wb_addr = 10'h055; Dc_wb_wline = w3;
        tick();
        Dc_wb_we = 1'b0;
        check("rb_busy", LB'(Dc_wb_busy), LB'(1));
        check("rb_req", LB'(mem_bus.Arb_mem_req), LB'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rb_req0", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("rb_we0", LB'(mem_bus.Arb_mem_we), LB'(0));
        check("rb_addr0", LB'(mem_bus.Arb_mem_addr), LB'(0));
        check("rb_wline0", mem_bus.Arb_mem_wline, '0);
        check("rb_busy0", LB'(Dc_wb_busy), LB'(0));
        check("rb_err0", LB'(Arb_err), LB'(0));
        check("rb_mline0", MEM_data_line, '0);
        check("rb_mvalid0", LB'(MEM_mem_valid), LB'(0));
        repeat (4) tick();
        check("rb_no_req", LB'(mem_bus.Arb_mem_req), LB'(0));
        check("rb_still_empty", LB'(Dc_wb_busy), LB'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache / D-cache line ports and a single-port unified backing memory.
- Serializes I-line reads, D-line reads and D-line write-backs onto one memory channel, one transaction at a time.
- Holds D write-backs in a 1-entry write buffer so the D-cache does not wait for the memory write.
- Includes a watchdog that flags a hung memory.

Parameters:
- LINE_BITS, 128, cache line width
- ADDR_BITS, 10, line index width
- TIMEOUT, 255, max cycles Arb_mem_req may stay high without Arb_mem_valid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Ic_mem_req  in  1  I-line read request; level, held until F_mem_valid
- Ic_mem_addr  in  ADDR_BITS  I-line index; stable while Ic_mem_req high
- F_mem_inst  out  LINE_BITS  I-line data; valid when F_mem_valid
- F_mem_valid  out  1  one-cycle I response pulse
- Dc_mem_req  in  1  D-line read request; level, held until MEM_mem_valid
- Dc_mem_addr  in  ADDR_BITS  D-line index
- MEM_data_line  out  LINE_BITS  D-line data
- MEM_mem_valid  out  1  one-cycle D response pulse
- Dc_wb_we  in  1  one-cycle write-back pulse; ignored while Dc_wb_busy
- Dc_wb_addr  in  ADDR_BITS  write-back line index
- Dc_wb_wline  in  LINE_BITS  write-back line data
- Dc_wb_busy  out  1  write buffer occupied
- Arb_mem_req  out  1  memory request; held until Arb_mem_valid
- Arb_mem_we  out  1  1 = write, 0 = read; stable with req
- Arb_mem_addr  out  ADDR_BITS  memory line index
- Arb_mem_wline  out  LINE_BITS  memory write data
- Arb_mem_rline  in  LINE_BITS  memory read data; valid with Arb_mem_valid
- Arb_mem_valid  in  1  one-cycle completion (read data or write ack)
- Arb_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE; write buffer empty; rr pointer = I; watchdog = 0. All outputs 0: lines, valids, Dc_wb_busy, Arb_* and Arb_err.
- Write buffer:
  - Dc_wb_we while not busy captures addr/line; Dc_wb_busy = 1 from the next cycle.
  - Buffer clears on the write's Arb_mem_valid edge.
  - Dc_wb_we while busy is dropped (D-cache protocol violation).
- IDLE grant order, evaluated each cycle:
  1. Write buffer non-empty.
  2. Otherwise round-robin between Ic_mem_req and Dc_mem_req. Only one pending: grant it. Both pending: grant the one not granted last.
- A grant registers the source, Arb_mem_addr, Arb_mem_we and Arb_mem_wline, and moves to BUSY. Arb_mem_req = 1 from the next cycle. The rr pointer updates on read grants only.
- Write-back vs D read: write priority guarantees a D read of a line with a buffered write-back is issued after that write. No forwarding.
- BUSY:
  - Watchdog increments each cycle.
  - On Arb_mem_valid: deassert Arb_mem_req at that edge. For a read, register Arb_mem_rline into F_mem_inst (I) or MEM_data_line (D). Go to RESP.
- RESP (exactly 1 cycle):
  - Read: pulse F_mem_valid or MEM_mem_valid; the line output holds its value until the next same-source response.
  - Write: no upstream pulse.
  - Then IDLE. RESP exists so the requester's still-high req during its valid cycle is never re-granted.
- Latency: the request is seen in IDLE at cycle 0, Arb_mem_req is high cycles 1..N with Arb_mem_valid in cycle N, and the upstream valid pulses in cycle N+1.
- Back-to-back: next grant decision is made in the cycle after RESP, giving a minimum 1 idle cycle between transactions.
- Watchdog: reaching TIMEOUT in BUSY sets Arb_err (sticky until rst), drops Arb_mem_req and goes to RESP.
  - Read: returns an all-zero line with the normal valid pulse.
  - Write: clears the buffer.
- Arb_mem_valid outside BUSY is ignored.
- rst mid-transaction: immediate return to reset state; an in-flight or buffered write is discarded.

Test Plan:
- I only, addr 0x005, memory valid in 3rd req cycle with line 0xA5..A5 -> Arb_mem_req cycles 1-3, addr 0x005, we = 0; F_mem_valid cycle 4 with line 0xA5..A5; MEM_mem_valid never.
- I and D asserted same cycle from reset (rr = I) -> D granted first, then I; second pair also alternates D then I; each responder gets exactly one pulse.
- Dc_wb_we addr 0x010 plus Dc_mem_req addr 0x010 same cycle -> write (we = 1, wline matches) issued before read; Dc_wb_busy 1 until write valid; read data returned afterwards.
- Second Dc_wb_we while busy -> dropped; only first line written to memory.
- Memory never asserts valid, TIMEOUT = 8 -> Arb_mem_req drops after 8 cycles; Arb_err = 1 sticky; requester gets a zero line with a valid pulse; next request is serviced normally.
- rst asserted while BUSY with buffer full -> next cycle all outputs 0, Dc_wb_busy = 0, no memory request until a new req arrives.
